// File: rtl/sub_pkg.sv
// sub_pkg: shared state encoding and default width for the serial subtractor.
//   Exports state_t (IDLE=0, RUN=1, DONE=2) and DEF_WIDTH (8).
package sub_pkg;
   localparam int DEF_WIDTH = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_sub.sv
// full_sub: one-bit full subtractor cell, complement of the full adder cell.
//   x, y  : minuend and subtrahend bits
//   bin   : borrow in
//   diff  : x - y - bin (mod 2)
//   bout  : borrow out
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);
   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, one bit per cycle LSB first, WIDTH+2 cycles per result.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE; a, b captured on acceptance
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse when d/bo are valid
//   d, bo      : difference (a - b) mod 2^WIDTH and final borrow (a < b unsigned)
//   ovf        : signed overflow, present only when SERIAL_SUB_OVF_EN is defined
module serial_sub
   import sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = $clog2(WIDTH);
   state_t           state;
   logic [WIDTH-1:0] sa, sb;
   logic [CW-1:0]    cnt;
   logic             bor, diff, bout, last;
   assign last = cnt == CW'(WIDTH - 1);
   assign bo   = bor;
   full_sub u_cell (
      .x   (sa[0]),
      .y   (sb[0]),
      .bin (bor),
      .diff(diff),
      .bout(bout)
   );
   // d doubles as the result shift register: diff bits enter at the MSB so
   // the word is aligned after WIDTH shifts and then simply held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bor   <= 1'b0;
         cnt   <= '0;
         sa    <= '0;
         sb    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               sa    <= a;
               sb    <= b;
               bor   <= 1'b0;
               cnt   <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               d   <= {diff, d[WIDTH-1:1]};
               bor <= bout;
               cnt <= cnt + CW'(1);
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                  // On the last bit sa[0]/sb[0] are the operand sign bits and diff is the result sign.
                  ovf   <= (sa[0] != sb[0]) && (diff != sa[0]);
`endif
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: self-checking bench for serial_sub (WIDTH=8) against an arithmetic reference model.
module tb_serial_sub;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, bo;
   logic [W-1:0] d;
   logic         ovf_o;
   int           errors = 0;
   int           checks = 0;

   always #5 clk = ~clk;

`ifdef SERIAL_SUB_OVF_EN
   serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
                                .busy(busy), .done(done), .d(d), .bo(bo), .ovf(ovf_o));
`else
   serial_sub #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
                                .busy(busy), .done(done), .d(d), .bo(bo));
   assign ovf_o = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] m_d(input logic [W-1:0] x, input logic [W-1:0] y);
      return W'((int'(x) - int'(y) + 256) % 256);
   endfunction

   function automatic logic m_bo(input logic [W-1:0] x, input logic [W-1:0] y);
      return int'(x) < int'(y);
   endfunction

   function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
      int r;
      r = int'($signed(x)) - int'($signed(y));
      return (r > 127) || (r < -128);
   endfunction

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // Full operation from the IDLE phase: accept at the next edge, expect done
   // exactly W edges later, then the IDLE return with results held.
   task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                     input bit chk_ovf);
      a = x;
      b = y;
      start = 1'b1;
      edge1();
      start = 1'b0;
      a = ~x;
      b = ~y;
      chk({tag, "_busy0"}, busy, 1);
      for (int k = 1; k <= W; k++) begin
         edge1();
         if (k < W) begin
            if (k == 1 || k == W - 1) chk({tag, "_nodone"}, done, 0);
         end else begin
            chk({tag, "_done"}, done, 1);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_d"}, d, m_d(x, y));
            chk({tag, "_bo"}, bo, m_bo(x, y));
`ifdef SERIAL_SUB_OVF_EN
            if (chk_ovf) chk({tag, "_ovf"}, ovf_o, m_ovf(x, y));
`endif
         end
      end
      edge1();
      chk({tag, "_done_off"}, done, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_d_hold"}, d, m_d(x, y));
      chk({tag, "_bo_hold"}, bo, m_bo(x, y));
   endtask

   initial begin
      logic [W-1:0] qa[$], qb[$];
      logic [W-1:0] ea, eb;
      int n, ndone, last_cyc, cyc;
      // Reset state
      repeat (3) edge1();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_d", d, 0);
      chk("rst_bo", bo, 0);
      chk("rst_ovf", ovf_o, 0);
      rst_n = 1'b1;
      // Directed operations
      op("t05_03", 8'h05, 8'h03, 1);
      op("t03_05", 8'h03, 8'h05, 1);
      op("t80_01", 8'h80, 8'h01, 1);
      op("t7f_ff", 8'h7F, 8'hFF, 1);
      // Start pulsed mid-RUN with new operands is ignored
      a = 8'hA5;
      b = 8'h3C;
      start = 1'b1;
      edge1();
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= W + 4; k++) begin
         if (k == 3) begin
            start = 1'b1;
            a = 8'h11;
            b = 8'h22;
         end else start = 1'b0;
         edge1();
         if (done) begin
            ndone++;
            chk("ign_d", d, m_d(8'hA5, 8'h3C));
            chk("ign_bo", bo, m_bo(8'hA5, 8'h3C));
            chk("ign_when", k, W);
         end
      end
      start = 1'b0;
      chk("ign_pulses", ndone, 1);
      // Reset in the middle of RUN
      a = 8'hC3;
      b = 8'h5A;
      start = 1'b1;
      edge1();
      start = 1'b0;
      repeat (4) edge1();
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_d", d, 0);
      chk("mrst_bo", bo, 0);
      chk("mrst_ovf", ovf_o, 0);
      edge1();
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < W + 4; k++) begin
         edge1();
         if (done) ndone++;
      end
      chk("mrst_nodone", ndone, 0);
      op("tff_ff", 8'hFF, 8'hFF, 1);
      // Back-to-back with start held high; operands are scrambled while busy
      n = 0;
      cyc = 0;
      last_cyc = -1;
      a = W'($urandom);
      b = W'($urandom);
      qa.push_back(a);
      qb.push_back(b);
      start = 1'b1;
      while (n < 1000 && cyc < 20000) begin
         edge1();
         cyc++;
         if (done) begin
            if (qa.size() == 0) begin
               chk("b2b_queue", 0, 1);
            end else begin
               ea = qa.pop_front();
               eb = qb.pop_front();
               chk("b2b_d", d, m_d(ea, eb));
               chk("b2b_bo", bo, m_bo(ea, eb));
`ifdef SERIAL_SUB_OVF_EN
               chk("b2b_ovf", ovf_o, m_ovf(ea, eb));
`endif
            end
            if (last_cyc >= 0) chk("b2b_period", cyc - last_cyc, W + 2);
            last_cyc = cyc;
            n++;
         end
         a = W'($urandom);
         b = W'($urandom);
         if (!busy) begin
            qa.push_back(a);
            qb.push_back(b);
         end
      end
      start = 1'b0;
      chk("b2b_count", n, 1000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend; captured on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend; captured on accepted start.
REQ-007 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: d  output  WIDTH  difference (a - b) mod 2^WIDTH.
REQ-010 SHALL have port: bo  output  1  final borrow-out; 1 iff a < b unsigned.
REQ-011 SHALL have port: ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 SHALL, on start=1 in IDLE, load a and b into shift registers, clear borrow FF and bit counter, and go to RUN.
REQ-014 SHALL, in RUN, process one bit per cycle, LSB first: diff = x^y^bin; bout = (~x&y)|(~(x^y)&bin).
REQ-015 SHALL shift each diff bit into the result register MSB-side, so d is bit-aligned after WIDTH shifts.
REQ-016 SHALL register bout into the borrow FF each RUN cycle; bo = borrow FF after the last bit.
REQ-017 SHALL go RUN->DONE after exactly WIDTH RUN cycles (counter reaches WIDTH-1), then DONE->IDLE unconditionally.
REQ-018 SHALL assert done only in DONE, for exactly one cycle: start accepted at edge N gives done high in the cycle after edge N+WIDTH.
REQ-019 SHALL hold d, bo (and ovf) stable from DONE until the next accepted start; they are undefined in RUN and not to be sampled then.
REQ-020 SHALL ignore start in RUN and DONE; no queuing; a/b changes after capture have no effect.
REQ-021 SHALL accept start on the first IDLE cycle after DONE, giving back-to-back throughput of one result per WIDTH+2 cycles.

Reset
REQ-022 SHALL, on rst_n low at any time (including mid-RUN), asynchronously force state=IDLE, busy=0, done=0, d=0, bo=0, ovf=0, and clear counter and borrow FF.
REQ-023 SHALL discard an aborted operation entirely and never emit done for it after reset release.
REQ-024 SHALL accept start from the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with SERIAL_SUB_OVF_EN defined, provide port ovf = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), registered with d, valid under the same rules as bo.
REQ-026 SHALL, without SERIAL_SUB_OVF_EN, have no ovf port and no associated logic; all other behaviour identical.

Structure
REQ-027 SHALL take state encodings (IDLE=0, RUN=1, DONE=2) and the default WIDTH from the shared package/header sub_pkg.
REQ-028 SHALL place the one-bit cell (REQ-014) in sub-module full_sub, with ports x, y, bin, bout, diff, as the complement of the existing full adder cell.

Verification
REQ-029 SHALL test WIDTH=8, a=0x05, b=0x03, start at edge 0 -> done at cycle 9 only, d=0x02, bo=0, busy high cycles 1..9.
REQ-030 SHALL test a=0x03, b=0x05 -> d=0xFE, bo=1; with macro ovf=0.
REQ-031 SHALL test, with macro, a=0x80, b=0x01 -> d=0x7F, bo=0, ovf=1; and a=0x7F, b=0xFF -> d=0x80, bo=1, ovf=1.
REQ-032 SHALL test start pulsed with new operands at RUN cycle 3 -> ignored; result matches first operands; single done pulse.
REQ-033 SHALL test rst_n low at RUN cycle 4 -> busy/done/d/bo=0 immediately; no done afterwards; next start 0xFF-0xFF -> d=0x00, bo=0.
REQ-034 SHALL test back-to-back starts held high -> done every 10 cycles; random 1000-pair compare against a-b mod 256.
